// File: rtl/bet_ledger_pkg.sv
// Shared definitions for the bet ledger: round-state encodings, special opcodes
// and the slot-width helper.
package bet_pkg;

    typedef enum logic [1:0] {
        ST_OPEN = 2'd0,
        ST_SPIN = 2'd1,
        ST_HOLD = 2'd2
    } round_state_t;

    localparam logic [5:0] SPIN_OPCODE = 6'h3E;
    localparam logic [5:0] IDLE_OPCODE = 6'h3F;
    localparam logic [5:0] UNDO_OPCODE = 6'h3D;

    function automatic int slot_w(input int color_w, input int opcode_w);
        return color_w + opcode_w;
    endfunction

endpackage

// File: rtl/bet_ledger_if.sv
// Keyboard/Arduino/processor side signals of the bet ledger, grouped with a
// master (stimulus/host) and slave (ledger) view.
interface bet_ledger_if #(
    parameter int MAX_BETS = 12,
    parameter int OPCODE_W = 6,
    parameter int COLOR_W  = 2
);
    localparam int SLOT_W = COLOR_W + OPCODE_W;
    localparam int CNT_W  = $clog2(MAX_BETS + 1);

    logic                       bet_strobe;
    logic [OPCODE_W-1:0]        bet_opcode;
    logic [2:0]                 chip_color;
    logic                       spin_done;
    logic                       round_clear;
    logic [MAX_BETS*SLOT_W-1:0] bets_flat;
    logic [CNT_W-1:0]           bet_count;
    logic                       full;
    logic                       spin_check;
    logic                       spin_start;
    logic                       reject;
    logic [1:0]                 round_state;

    modport master (
        output bet_strobe, bet_opcode, chip_color, spin_done, round_clear,
        input  bets_flat, bet_count, full, spin_check, spin_start, reject, round_state
    );

    modport slave (
        input  bet_strobe, bet_opcode, chip_color, spin_done, round_clear,
        output bets_flat, bet_count, full, spin_check, spin_start, reject, round_state
    );

endinterface

// File: rtl/bet_ledger_strobe_rise_detect.sv
// Turns the keyboard data-ready level into a single-cycle event on its rising edge.
module strobe_rise_detect (
    input  logic clock,
    input  logic reset,
    input  logic strobe,
    output logic pulse
);
    logic prev;

    always_ff @(posedge clock) begin
        if (reset) prev <= 1'b0;
        else       prev <= strobe;
    end

    assign pulse = strobe & ~prev;

endmodule

// File: rtl/bet_ledger.sv
// Bet capture ledger with OPEN/SPIN/HOLD round control.
// Optional macro BET_UNDO_EN: opcode 6'h3D removes the most recent bet while OPEN.
module bet_ledger #(
    parameter int                  MAX_BETS    = 12,
    parameter int                  OPCODE_W    = 6,
    parameter int                  COLOR_W     = 2,
    parameter logic [OPCODE_W-1:0] SPIN_OPCODE = OPCODE_W'(bet_pkg::SPIN_OPCODE),
    parameter logic [OPCODE_W-1:0] IDLE_OPCODE = OPCODE_W'(bet_pkg::IDLE_OPCODE)
) (
    input logic         clock,
    input logic         reset,
    bet_ledger_if.slave bus
);
    import bet_pkg::*;

    localparam int SLOT_W = slot_w(COLOR_W, OPCODE_W);
    localparam int CNT_W  = $clog2(MAX_BETS + 1);
    localparam logic [CNT_W-1:0]    FULL_COUNT = CNT_W'(MAX_BETS);
    localparam logic [OPCODE_W-1:0] UNDO_OP    = OPCODE_W'(UNDO_OPCODE);
`ifdef BET_UNDO_EN
    localparam bit UNDO_ENABLED = 1'b1;
`else
    localparam bit UNDO_ENABLED = 1'b0;
`endif

    logic [SLOT_W-1:0] slots [MAX_BETS];
    logic [CNT_W-1:0]  count;
    round_state_t      state;
    logic              spin_start_r;
    logic              reject_r;
    logic              ev;
    logic              is_full;
    logic              has_chip;
    logic [MAX_BETS*SLOT_W-1:0] flat;

    strobe_rise_detect u_rise (
        .clock  (clock),
        .reset  (reset),
        .strobe (bus.bet_strobe),
        .pulse  (ev)
    );

    assign is_full  = (count == FULL_COUNT);
    assign has_chip = (bus.chip_color != 3'b000);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_OPEN;
            count        <= '0;
            spin_start_r <= 1'b0;
            reject_r     <= 1'b0;
            for (int k = 0; k < MAX_BETS; k++) slots[k] <= '0;
        end else begin
            spin_start_r <= 1'b0;
            reject_r     <= 1'b0;
            unique case (state)
                ST_OPEN: begin
                    // A clear discards any event arriving in the same cycle.
                    if (bus.round_clear) begin
                        count <= '0;
                        for (int k = 0; k < MAX_BETS; k++) slots[k] <= '0;
                    end else if (ev) begin
                        if (bus.bet_opcode == IDLE_OPCODE) begin
                            // no key pressed: nothing to record or refuse
                        end else if (bus.bet_opcode == SPIN_OPCODE) begin
                            if (count != '0) begin
                                state        <= ST_SPIN;
                                spin_start_r <= 1'b1;
                            end else begin
                                reject_r <= 1'b1;
                            end
                        end else if (UNDO_ENABLED && bus.bet_opcode == UNDO_OP) begin
                            if (count != '0) begin
                                count <= count - 1'b1;
                                for (int k = 0; k < MAX_BETS; k++)
                                    if (CNT_W'(k) == count - 1'b1) slots[k] <= '0;
                            end else begin
                                reject_r <= 1'b1;
                            end
                        end else if (has_chip && !is_full) begin
                            count <= count + 1'b1;
                            for (int k = 0; k < MAX_BETS; k++)
                                if (CNT_W'(k) == count)
                                    slots[k] <= {bus.chip_color[COLOR_W-1:0], bus.bet_opcode};
                        end else begin
                            reject_r <= 1'b1;
                        end
                    end
                end
                ST_SPIN: begin
                    if (ev)            reject_r <= 1'b1;
                    if (bus.spin_done) state    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (ev) reject_r <= 1'b1;
                    if (bus.round_clear) begin
                        state <= ST_OPEN;
                        count <= '0;
                        for (int k = 0; k < MAX_BETS; k++) slots[k] <= '0;
                    end
                end
                default: state <= ST_OPEN;
            endcase
        end
    end

    always_comb begin
        flat = '0;
        for (int k = 0; k < MAX_BETS; k++) flat[k*SLOT_W +: SLOT_W] = slots[k];
    end

    assign bus.bets_flat   = flat;
    assign bus.bet_count   = count;
    assign bus.full        = is_full;
    assign bus.spin_check  = (state == ST_SPIN);
    assign bus.spin_start  = spin_start_r;
    assign bus.reject      = reject_r;
    assign bus.round_state = state;

endmodule

// File: tb/tb_bet_ledger.sv
// Directed bench for bet_ledger: a queue-based round model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_bet_ledger;
    localparam int MAX_BETS = 12;
    localparam int OPCODE_W = 6;
    localparam int COLOR_W  = 2;
`ifdef BET_UNDO_EN
    localparam bit UNDO_ON = 1'b1;
`else
    localparam bit UNDO_ON = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    bet_ledger_if #(.MAX_BETS(MAX_BETS), .OPCODE_W(OPCODE_W), .COLOR_W(COLOR_W)) bus ();

    bet_ledger #(.MAX_BETS(MAX_BETS), .OPCODE_W(OPCODE_W), .COLOR_W(COLOR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round model: a queue of stored slot bytes and a small state number.
    logic [7:0] m_q[$];
    int         m_state = 0;
    bit         m_prev = 0, m_spin_start = 0, m_reject = 0;

    always @(posedge clock) begin
        bit ev;
        if (reset) begin
            m_q.delete(); m_state = 0; m_prev = 0; m_spin_start = 0; m_reject = 0;
        end else begin
            ev = bus.bet_strobe && !m_prev;
            m_prev = bus.bet_strobe;
            m_spin_start = 0;
            m_reject = 0;
            if (m_state == 0) begin
                if (bus.round_clear) m_q.delete();
                else if (ev) begin
                    if (bus.bet_opcode == 6'h3F) ;
                    else if (bus.bet_opcode == 6'h3E) begin
                        if (m_q.size() > 0) begin m_state = 1; m_spin_start = 1; end
                        else m_reject = 1;
                    end else if (UNDO_ON && bus.bet_opcode == 6'h3D) begin
                        if (m_q.size() > 0) void'(m_q.pop_back());
                        else m_reject = 1;
                    end else if (bus.chip_color != 0 && m_q.size() < MAX_BETS)
                        m_q.push_back({bus.chip_color[1:0], bus.bet_opcode});
                    else m_reject = 1;
                end
            end else if (m_state == 1) begin
                if (ev) m_reject = 1;
                if (bus.spin_done) m_state = 2;
            end else begin
                if (ev) m_reject = 1;
                if (bus.round_clear) begin m_state = 0; m_q.delete(); end
            end
        end
    end

    function automatic logic [127:0] m_flat();
        logic [127:0] f = '0;
        foreach (m_q[i]) f[i*8 +: 8] = m_q[i];
        return f;
    endfunction

    always @(negedge clock) begin
        if (checking) begin
            chk("bets_flat",   128'(bus.bets_flat),   m_flat());
            chk("bet_count",   128'(bus.bet_count),   128'(m_q.size()));
            chk("full",        128'(bus.full),        128'(m_q.size() == MAX_BETS));
            chk("spin_check",  128'(bus.spin_check),  128'(m_state == 1));
            chk("spin_start",  128'(bus.spin_start),  128'(m_spin_start));
            chk("reject",      128'(bus.reject),      128'(m_reject));
            chk("round_state", 128'(bus.round_state), 128'(m_state));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [5:0] op, input logic [2:0] col);
        bus.bet_strobe = 1'b1; bus.bet_opcode = op; bus.chip_color = col;
        tick(1);
    endtask

    task automatic lift();
        bus.bet_strobe = 1'b0;
        tick(1);
    endtask

    task automatic bet(input logic [5:0] op, input logic [2:0] col);
        press(op, col);
        lift();
    endtask

    task automatic clear_round();
        bus.round_clear = 1'b1; tick(1);
        bus.round_clear = 1'b0; tick(1);
    endtask

    initial begin
        bus.bet_strobe = 0; bus.bet_opcode = '0; bus.chip_color = '0;
        bus.spin_done = 0; bus.round_clear = 0;
        tick(2);
        checking = 1'b1;
        chk("reset_count", 128'(bus.bet_count), 128'(0));
        chk("reset_state", 128'(bus.round_state), 128'(0));
        reset = 1'b0;
        tick(1);

        // Held strobe produces exactly one stored bet.
        bus.bet_strobe = 1; bus.bet_opcode = 6'h05; bus.chip_color = 3'b101;
        tick(5);
        lift();
        chk("slot0_held", 128'(bus.bets_flat[7:0]), 128'(8'h45));
        chk("count_held", 128'(bus.bet_count), 128'(1));

        // Idle opcode and colourless bet.
        bet(6'h3F, 3'b001);
        chk("idle_count", 128'(bus.bet_count), 128'(1));
        press(6'h09, 3'b000);
        chk("nochip_reject", 128'(bus.reject), 128'(1));
        lift();
        clear_round();
        chk("clear_count", 128'(bus.bet_count), 128'(0));

        // Fill to capacity, then overflow.
        for (int i = 1; i <= 12; i++) bet(6'(i), 3'b001);
        chk("full_count", 128'(bus.bet_count), 128'(12));
        chk("full_flag", 128'(bus.full), 128'(1));
        chk("slot11", 128'(bus.bets_flat[95:88]), 128'(8'h4C));
        press(6'h0D, 3'b001);
        chk("overflow_reject", 128'(bus.reject), 128'(1));
        lift();
        chk("overflow_count", 128'(bus.bet_count), 128'(12));
        clear_round();

        // Spin requests.
        press(6'h3E, 3'b000);
        chk("empty_spin_reject", 128'(bus.reject), 128'(1));
        lift();
        bet(6'h11, 3'b010);
        bet(6'h12, 3'b011);
        press(6'h3E, 3'b000);
        chk("spin_start", 128'(bus.spin_start), 128'(1));
        chk("spin_state", 128'(bus.round_state), 128'(1));
        chk("spin_check", 128'(bus.spin_check), 128'(1));
        lift();
        chk("spin_start_drop", 128'(bus.spin_start), 128'(0));
        press(6'h13, 3'b001);
        chk("spin_bet_reject", 128'(bus.reject), 128'(1));
        lift();
        bus.round_clear = 1; tick(1); bus.round_clear = 0;
        chk("spin_ignores_clear", 128'(bus.round_state), 128'(1));

        // Hold and payout clear.
        bus.spin_done = 1; tick(1); bus.spin_done = 0;
        chk("hold_state", 128'(bus.round_state), 128'(2));
        press(6'h14, 3'b001);
        chk("hold_reject", 128'(bus.reject), 128'(1));
        lift();
        chk("hold_frozen", 128'(bus.bets_flat[15:0]), 128'(16'hD2_91));
        bus.round_clear = 1; tick(1); bus.round_clear = 0;
        chk("cleared_state", 128'(bus.round_state), 128'(0));
        chk("cleared_flat", 128'(bus.bets_flat), 128'(0));
        tick(1);

        // Clear wins over a same-cycle bet; reset mid-spin.
        bus.round_clear = 1; bus.bet_strobe = 1; bus.bet_opcode = 6'h07; bus.chip_color = 3'b001;
        tick(1);
        bus.round_clear = 0;
        chk("clear_wins_count", 128'(bus.bet_count), 128'(0));
        chk("clear_wins_noreject", 128'(bus.reject), 128'(0));
        lift();
        bet(6'h01, 3'b001);
        bet(6'h02, 3'b001);
        bet(6'h3E, 3'b000);
        chk("pre_reset_spin", 128'(bus.round_state), 128'(1));
        reset = 1; tick(1); reset = 0;
        chk("reset_spin_state", 128'(bus.round_state), 128'(0));
        chk("reset_spin_count", 128'(bus.bet_count), 128'(0));
        tick(1);

        // Undo opcode.
        bet(6'h01, 3'b001);
        bet(6'h02, 3'b001);
        bet(6'h03, 3'b001);
        bet(6'h3D, 3'b001);
        if (UNDO_ON) begin
            chk("undo_count", 128'(bus.bet_count), 128'(2));
            chk("undo_slot2", 128'(bus.bets_flat[23:16]), 128'(0));
        end else begin
            chk("plain_3d_count", 128'(bus.bet_count), 128'(4));
            chk("plain_3d_slot3", 128'(bus.bets_flat[29:24]), 128'(6'h3D));
        end
        tick(2);

        checking = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
